// File: rtl/multitap_effects.sv
// multitap_effects: multi-tap delay/echo effect over an external delay RAM,
// with tap accumulation, overdrive, saturation and solo shaping.
module multitap_effects #(
    parameter int DW         = 10,
    parameter int AW         = 13,
    parameter int NTAPS      = 4,
    parameter int BASE_DELAY = 256,
    parameter int NOISE_OFS  = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sampleValid,
    input  logic [DW-1:0]    sampleVoltage,
    input  logic [DW-1:0]    offset,
    input  logic [NTAPS-1:0] tapEnable,
    input  logic             overdrive,
    input  logic             solo,
    input  logic             userMode,
    input  logic [3:0]       intensity,
    input  logic [DW:0]      readVoltage,
    output logic [AW-1:0]    address,
    output logic             writeEnable,
    output logic [DW:0]      writeVoltage,
    output logic [DW:0]      sendVoltage,
    output logic             sendValid,
    output logic             busy,
    output logic             overrun
);
    localparam int ACCW = DW + 6;
    typedef enum logic [2:0] {IDLE, WRITE, TAP, DRAIN, OUTPUT} state_t;
    state_t state;
    logic [2:0] tap, prev;
    logic [7:0] en_all;
    logic [AW-1:0] write_adr, delay;
    logic [ACCW-1:0] acc, acc_sum, new_ov, abs_v, driven, thresh, sat;
    logic [DW-1:0] ov_mag, rd_mag, neg_sat, mag;
    logic take;

    assign new_ov = ACCW'(sampleVoltage) - ACCW'(offset) + ACCW'(NOISE_OFS);
    assign ov_mag = DW'(new_ov[ACCW-1] ? -new_ov : new_ov);
    assign delay = userMode ? AW'((32'(intensity) + 1) * (32'(tap) + 1) * 128)
                            : AW'(BASE_DELAY * (32'(tap) + 1));
    assign address = (state == TAP) ? write_adr - delay : write_adr;
    assign writeEnable = (state == WRITE);
    assign busy = (state != IDLE);
    // read data lags the address by one cycle, so each state consumes the previous tap
    assign prev = (state == DRAIN) ? tap : tap - 3'd1;
    assign en_all = 8'(tapEnable);
    assign rd_mag = (prev == 3'd0) ? readVoltage[DW-1:0] : readVoltage[DW-1:0] >> 1;
    assign acc_sum = readVoltage[DW] ? acc - ACCW'(rd_mag) : acc + ACCW'(rd_mag);
    assign take = en_all[prev] && ((state == TAP && tap != 3'd0) || state == DRAIN);

    always_comb begin
        abs_v = acc[ACCW-1] ? -acc : acc;
        driven = (overdrive && abs_v > ACCW'(31)) ? abs_v << (userMode ? intensity : 4'd2) : abs_v;
        thresh = !overdrive ? ACCW'(2**DW - 1) : !userMode ? ACCW'(255) : (ACCW'(intensity) << 6) + ACCW'(126);
        sat = (driven > thresh) ? thresh : driven;
        neg_sat = DW'(-sat);
        mag = !solo ? sat[DW-1:0] : (sat < ACCW'(15)) ? '0 : neg_sat >> 1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            tap          <= '0;
            write_adr    <= '0;
            acc          <= '0;
            writeVoltage <= '0;
            sendVoltage  <= '0;
            sendValid    <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            sendValid <= 1'b0;
            if (sampleValid && state != IDLE)
                overrun <= 1'b1;
            case (state)
                IDLE: if (sampleValid) begin
                    acc          <= new_ov;
                    writeVoltage <= {new_ov[ACCW-1], ov_mag};
                    state        <= WRITE;
                end
                WRITE: begin
                    tap   <= '0;
                    state <= TAP;
                end
                TAP: begin
                    if (take)
                        acc <= acc_sum;
                    if (tap == 3'(NTAPS - 1))
                        state <= DRAIN;
                    else
                        tap <= tap + 3'd1;
                end
                DRAIN: begin
                    if (take)
                        acc <= acc_sum;
                    state <= OUTPUT;
                end
                OUTPUT: begin
                    sendVoltage <= {acc[ACCW-1], mag};
                    sendValid   <= 1'b1;
                    write_adr   <= write_adr + 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multitap_effects.sv
// tb_multitap_effects: directed bench for multitap_effects with a one-cycle-latency RAM model.
module tb_multitap_effects;
    localparam int DW = 10;
    localparam int AW = 13;
    localparam int NTAPS = 4;

    logic clk = 1'b0;
    logic reset;
    logic sampleValid;
    logic [DW-1:0] sampleVoltage, offset;
    logic [NTAPS-1:0] tapEnable;
    logic overdrive, solo, userMode;
    logic [3:0] intensity;
    logic [DW:0] readVoltage;
    logic [AW-1:0] address;
    logic writeEnable;
    logic [DW:0] writeVoltage, sendVoltage;
    logic sendValid, busy, overrun;

    logic [DW:0] ram [0:(1<<AW)-1];
    logic poke;
    logic [AW-1:0] poke_addr;
    logic [DW:0] poke_data;
    logic [AW-1:0] wa;
    int checks = 0;
    int passed = 0;

    multitap_effects dut (
        .clk(clk), .reset(reset), .sampleValid(sampleValid),
        .sampleVoltage(sampleVoltage), .offset(offset), .tapEnable(tapEnable),
        .overdrive(overdrive), .solo(solo), .userMode(userMode),
        .intensity(intensity), .readVoltage(readVoltage), .address(address),
        .writeEnable(writeEnable), .writeVoltage(writeVoltage),
        .sendVoltage(sendVoltage), .sendValid(sendValid), .busy(busy),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (writeEnable)
            ram[address] <= writeVoltage;
        else if (poke)
            ram[poke_addr] <= poke_data;
        readVoltage <= ram[address];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [DW-1:0] s, input logic [DW-1:0] o);
        sampleVoltage = s;
        offset = o;
        sampleValid = 1'b1;
        tick();
        sampleValid = 1'b0;
    endtask

    task automatic wait_out(output int n, output logic [DW:0] v);
        n = 0;
        while (sendValid !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        v = sendVoltage;
        wa = wa + 1'b1;
    endtask

    task automatic fill(input logic [AW-1:0] target);
        while (wa != target) begin
            strobe(0, 0);
            repeat (7) tick();
            wa = wa + 1'b1;
        end
    endtask

    task automatic do_poke(input logic [AW-1:0] a, input logic [DW:0] d);
        poke = 1'b1;
        poke_addr = a;
        poke_data = d;
        tick();
        poke = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if ({address, writeEnable, writeVoltage, sendVoltage, sendValid, busy, overrun} !== '0)
            $display("FAIL reset_outputs: got adr=%h we=%b wv=%h sv=%h svld=%b busy=%b ovr=%b, expected all 0",
                     address, writeEnable, writeVoltage, sendVoltage, sendValid, busy, overrun);
        else passed++;
    endtask

    task automatic test_dry();
        int n;
        logic [DW:0] v;
        tapEnable = '0;
        strobe(600, 512);
        checks++; if (writeEnable !== 1'b1 || address !== 13'h0000) $display("FAIL dry_write: got we=%b adr=%h, expected we=1 adr=0000", writeEnable, address); else passed++;
        checks++; if (writeVoltage !== 11'h067) $display("FAIL dry_wvolt: got %h expected 067", writeVoltage); else passed++;
        checks++; if (busy !== 1'b1) $display("FAIL dry_busy: got %b expected 1", busy); else passed++;
        wait_out(n, v);
        checks++; if (n !== 7) $display("FAIL dry_latency: got %0d expected 7", n); else passed++;
        checks++; if (v !== 11'h067) $display("FAIL dry_send: got %h expected 067", v); else passed++;
        tick();
        checks++; if (sendValid !== 1'b0 || sendVoltage !== 11'h067 || busy !== 1'b0)
            $display("FAIL dry_hold: got svld=%b sv=%h busy=%b, expected 0 067 0", sendValid, sendVoltage, busy);
        else passed++;
    endtask

    task automatic test_taps();
        int n;
        logic [DW:0] v;
        fill(13'h0300);
        do_poke(13'h0200, {1'b0, 10'd100});
        do_poke(13'h0100, {1'b1, 10'd40});
        tapEnable = 4'b0011;
        strobe(600, 512);
        checks++; if (address !== 13'h0300) $display("FAIL taps_write_adr: got %h expected 0300", address); else passed++;
        tick();
        checks++; if (address !== 13'h0200 || writeEnable !== 1'b0) $display("FAIL taps_tap0: got adr=%h we=%b, expected 0200 0", address, writeEnable); else passed++;
        tick();
        checks++; if (address !== 13'h0100) $display("FAIL taps_tap1: got %h expected 0100", address); else passed++;
        wait_out(n, v);
        checks++; if (v !== 11'h0B7) $display("FAIL taps_send: got %h expected 0b7", v); else passed++;
        tapEnable = '0;
    endtask

    task automatic test_wrap();
        int n;
        logic [DW:0] v;
        fill(13'h1FFF);
        checks++; if (overrun !== 1'b0) $display("FAIL b2b_overrun: got %b expected 0", overrun); else passed++;
        strobe(600, 512);
        checks++; if (address !== 13'h1FFF) $display("FAIL wrap_write_adr: got %h expected 1fff", address); else passed++;
        tick();
        checks++; if (address !== 13'h1EFF) $display("FAIL wrap_tap0: got %h expected 1eff", address); else passed++;
        wait_out(n, v);
        strobe(600, 512);
        checks++; if (address !== 13'h0000) $display("FAIL wrap_next_adr: got %h expected 0000", address); else passed++;
        wait_out(n, v);
    endtask

    task automatic test_shaping();
        int n;
        logic [DW:0] v;
        overdrive = 1'b1;
        strobe(597, 512);
        wait_out(n, v);
        checks++; if (v !== 11'h0FF) $display("FAIL od_sat255: got %h expected 0ff", v); else passed++;
        strobe(477, 512);
        checks++; if (writeVoltage !== 11'h414) $display("FAIL od_neg_wvolt: got %h expected 414", writeVoltage); else passed++;
        wait_out(n, v);
        checks++; if (v !== 11'h414) $display("FAIL od_neg: got %h expected 414", v); else passed++;
        strobe(528, 512);
        wait_out(n, v);
        checks++; if (v !== 11'h01F) $display("FAIL od_thresh31: got %h expected 01f", v); else passed++;
        userMode = 1'b1;
        intensity = 4'd2;
        strobe(597, 512);
        tick();
        checks++; if (address !== 13'(wa - 13'd384)) $display("FAIL user_tap0: got %h expected %h", address, 13'(wa - 13'd384)); else passed++;
        tick();
        checks++; if (address !== 13'(wa - 13'd768)) $display("FAIL user_tap1: got %h expected %h", address, 13'(wa - 13'd768)); else passed++;
        wait_out(n, v);
        checks++; if (v !== 11'h0FE) $display("FAIL user_od: got %h expected 0fe", v); else passed++;
        userMode = 1'b0;
        intensity = 4'd0;
        overdrive = 1'b0;
        strobe(1023, 0);
        wait_out(n, v);
        checks++; if (v !== 11'h3FF) $display("FAIL sat1023: got %h expected 3ff", v); else passed++;
        solo = 1'b1;
        strobe(597, 512);
        wait_out(n, v);
        checks++; if (v !== 11'h1CE) $display("FAIL solo100: got %h expected 1ce", v); else passed++;
        strobe(507, 512);
        wait_out(n, v);
        checks++; if (v !== 11'h000) $display("FAIL solo10: got %h expected 000", v); else passed++;
        strobe(512, 512);
        wait_out(n, v);
        checks++; if (v !== 11'h1F8) $display("FAIL solo15: got %h expected 1f8", v); else passed++;
        solo = 1'b0;
    endtask

    task automatic test_overrun();
        int sends = 0;
        strobe(600, 512);
        tick();
        sampleValid = 1'b1;
        tick();
        sampleValid = 1'b0;
        checks++; if (overrun !== 1'b1) $display("FAIL overrun_set: got %b expected 1", overrun); else passed++;
        repeat (15) begin
            tick();
            if (sendValid) sends++;
        end
        wa = wa + 1'b1;
        checks++; if (sends !== 1) $display("FAIL overrun_sends: got %0d expected 1", sends); else passed++;
        checks++; if (overrun !== 1'b1) $display("FAIL overrun_sticky: got %b expected 1", overrun); else passed++;
    endtask

    task automatic test_reset_mid();
        int n;
        logic [DW:0] v;
        strobe(600, 512);
        repeat (3) tick();
        #2;
        reset = 1'b1;
        #1;
        checks++; if ({address, writeEnable, writeVoltage, sendVoltage, sendValid, busy, overrun} !== '0)
            $display("FAIL midreset_async: got adr=%h we=%b wv=%h sv=%h svld=%b busy=%b ovr=%b, expected all 0",
                     address, writeEnable, writeVoltage, sendVoltage, sendValid, busy, overrun);
        else passed++;
        tick();
        checks++; if ({address, sendValid, busy, overrun} !== '0) $display("FAIL midreset_edge: got adr=%h svld=%b busy=%b ovr=%b, expected 0", address, sendValid, busy, overrun); else passed++;
        reset = 1'b0;
        wa = '0;
        repeat (3) tick();
        checks++; if (busy !== 1'b0 || sendValid !== 1'b0) $display("FAIL midreset_idle: got busy=%b svld=%b expected 0 0", busy, sendValid); else passed++;
        strobe(600, 512);
        checks++; if (address !== 13'h0000 || writeVoltage !== 11'h067) $display("FAIL midreset_write: got adr=%h wv=%h expected 0000 067", address, writeVoltage); else passed++;
        wait_out(n, v);
        checks++; if (n !== 7 || v !== 11'h067) $display("FAIL midreset_send: got n=%0d v=%h expected 7 067", n, v); else passed++;
    endtask

    initial begin
        reset = 1'b1;
        sampleValid = 1'b0;
        sampleVoltage = '0;
        offset = '0;
        tapEnable = '0;
        overdrive = 1'b0;
        solo = 1'b0;
        userMode = 1'b0;
        intensity = '0;
        poke = 1'b0;
        poke_addr = '0;
        poke_data = '0;
        wa = '0;
        repeat (2) tick();
        test_reset();
        reset = 1'b0;
        tick();
        test_dry();
        test_taps();
        test_wrap();
        test_shaping();
        test_overrun();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
